uart_line_monitor: RTL and testbench

Passive serial-line monitor for the UART protocol checker; it taps one inter-UART wire (uart_0to1 or uart_1to0) downstream of a uart_top transmitter.
It decodes each frame with the same line settings as the UART under test and reports data, parity, framing and break status per frame.
It keeps frame and error counters for the scoreboard.
It never drives the line.

---
 rtl/uart_line_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_line_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_monitor.sv
// Passive UART line monitor: decodes frames off a tapped serial wire and reports
// data, parity/framing/break status per frame plus frame and error counters.
module uart_line_monitor #(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             uart_line,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [1:0]       cfg_wls,
   input  logic             cfg_pen,
   input  logic             cfg_eps,
   input  logic             cfg_stb,
   output logic             mon_valid,
   output logic [7:0]       mon_data,
   output logic             mon_perr,
   output logic             mon_ferr,
   output logic             mon_break,
   output logic             mon_busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned   DATA_W  = 8;
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_e;

   state_e              state_q, state_d;
   logic                sync1_q, sync2_q, prev_q;
   logic [DIV_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [1:0]          wls_q, wls_d;
   logic                pen_q, pen_d, eps_q, eps_d, stb_q, stb_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic                stop_idx_q, stop_idx_d;
   logic                par_q, par_d, zero_q, zero_d;
   logic                perr_q, perr_d, ferr_q, ferr_d;
   logic                mon_valid_q, mon_valid_d;
   logic [DATA_W-1:0]   mon_data_q, mon_data_d;
   logic                mon_perr_q, mon_perr_d, mon_ferr_q, mon_ferr_d;
   logic                mon_break_q, mon_break_d, mon_busy_q, mon_busy_d;
   logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

   logic [DIV_W-1:0]    div_eff;
   logic                tick, sample, ferr_n, zero_n, is_brk, is_err;

   // Next-state, datapath and report logic
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      div_d       = div_q;
      wls_d       = wls_q;
      pen_d       = pen_q;
      eps_d       = eps_q;
      stb_d       = stb_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      par_d       = par_q;
      zero_d      = zero_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      mon_valid_d = 1'b0;
      mon_data_d  = mon_data_q;
      mon_perr_d  = mon_perr_q;
      mon_ferr_d  = mon_ferr_q;
      mon_break_d = mon_break_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      ferr_n      = 1'b0;
      zero_n      = 1'b0;
      is_brk      = 1'b0;
      is_err      = 1'b0;

      div_eff = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
      tick    = (bit_cnt_q == '0);
      sample  = sync2_q;

      if (state_q != IDLE && state_q != BRKWAIT) begin
         bit_cnt_d = tick ? (div_q - DIV_W'(1)) : (bit_cnt_q - DIV_W'(1));
      end

      case (state_q)
         IDLE: begin
            if (!sync2_q && prev_q) begin
               state_d    = START;
               bit_cnt_d  = div_eff >> 1;
               div_d      = div_eff;
               wls_d      = cfg_wls;
               pen_d      = cfg_pen;
               eps_d      = cfg_eps;
               stb_d      = cfg_stb;
               shift_d    = '0;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               par_d      = 1'b0;
               zero_d     = 1'b1;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
            end
         end
         START: begin
            if (tick) state_d = sample ? IDLE : DATA;
         end
         DATA: begin
            if (tick) begin
               shift_d[bit_idx_q] = sample;
               par_d     = par_q ^ sample;
               zero_d    = zero_q & ~sample;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == (3'(wls_q) + 3'd4)) state_d = pen_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (tick) begin
               perr_d  = eps_q ? (par_q ^ sample) : ~(par_q ^ sample);
               zero_d  = zero_q & ~sample;
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               ferr_n     = ferr_q | ~sample;
               zero_n     = zero_q & ~sample;
               ferr_d     = ferr_n;
               zero_d     = zero_n;
               stop_idx_d = 1'b1;
               if (stop_idx_q == stb_q) begin
                  // Last stop sample: publish the frame
                  is_brk      = zero_n;
                  is_err      = is_brk | perr_q | ferr_n;
                  mon_valid_d = 1'b1;
                  mon_data_d  = is_brk ? '0 : shift_q;
                  mon_perr_d  = ~is_brk & perr_q;
                  mon_ferr_d  = ~is_brk & ferr_n;
                  mon_break_d = is_brk;
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
                  if (is_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
                  state_d     = is_brk ? BRKWAIT : IDLE;
               end
            end
         end
         BRKWAIT: begin
            if (sync2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      mon_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         div_q       <= DIV_MIN;
         wls_q       <= '0;
         pen_q       <= 1'b0;
         eps_q       <= 1'b0;
         stb_q       <= 1'b0;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         par_q       <= 1'b0;
         zero_q      <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         mon_valid_q <= 1'b0;
         mon_data_q  <= '0;
         mon_perr_q  <= 1'b0;
         mon_ferr_q  <= 1'b0;
         mon_break_q <= 1'b0;
         mon_busy_q  <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         sync1_q     <= uart_line;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         div_q       <= div_d;
         wls_q       <= wls_d;
         pen_q       <= pen_d;
         eps_q       <= eps_d;
         stb_q       <= stb_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         par_q       <= par_d;
         zero_q      <= zero_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         mon_valid_q <= mon_valid_d;
         mon_data_q  <= mon_data_d;
         mon_perr_q  <= mon_perr_d;
         mon_ferr_q  <= mon_ferr_d;
         mon_break_q <= mon_break_d;
         mon_busy_q  <= mon_busy_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign mon_valid = mon_valid_q;
   assign mon_data  = mon_data_q;
   assign mon_perr  = mon_perr_q;
   assign mon_ferr  = mon_ferr_q;
   assign mon_break = mon_break_q;
   assign mon_busy  = mon_busy_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_line_monitor.sv
// Directed bench for uart_line_monitor: drives serial frames by hand and checks
// each report and the counters; a 3-bit-counter instance covers wrap/saturation.
module tb_uart_line_monitor;

   localparam int unsigned DIV_W = 16;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned SAT_W = 3;
   localparam int          DIV   = 16;

   logic             pclk = 1'b0;
   logic             preset_n = 1'b0;
   logic             uart_line = 1'b1;
   logic [DIV_W-1:0] cfg_div = DIV_W'(DIV);
   logic [1:0]       cfg_wls = 2'b11;
   logic             cfg_pen = 1'b0;
   logic             cfg_eps = 1'b0;
   logic             cfg_stb = 1'b0;

   logic             mon_valid, mon_perr, mon_ferr, mon_break, mon_busy;
   logic [7:0]       mon_data;
   logic [CNT_W-1:0] frame_cnt, err_cnt;

   logic             s_valid, s_perr, s_ferr, s_break, s_busy;
   logic [7:0]       s_data;
   logic [SAT_W-1:0] s_frame_cnt, s_err_cnt;

   int total = 0;
   int bad = 0;
   int valid_cnt = 0;
   int v0;
   int ef = 0;
   int ee = 0;
   logic [7:0] cap_data = '0;
   logic cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;

   uart_line_monitor #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_dut (
      .pclk(pclk), .preset_n(preset_n), .uart_line(uart_line),
      .cfg_div(cfg_div), .cfg_wls(cfg_wls), .cfg_pen(cfg_pen),
      .cfg_eps(cfg_eps), .cfg_stb(cfg_stb),
      .mon_valid(mon_valid), .mon_data(mon_data), .mon_perr(mon_perr),
      .mon_ferr(mon_ferr), .mon_break(mon_break), .mon_busy(mon_busy),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   uart_line_monitor #(.DIV_W(DIV_W), .CNT_W(SAT_W)) u_dut_sat (
      .pclk(pclk), .preset_n(preset_n), .uart_line(uart_line),
      .cfg_div(cfg_div), .cfg_wls(cfg_wls), .cfg_pen(cfg_pen),
      .cfg_eps(cfg_eps), .cfg_stb(cfg_stb),
      .mon_valid(s_valid), .mon_data(s_data), .mon_perr(s_perr),
      .mon_ferr(s_ferr), .mon_break(s_break), .mon_busy(s_busy),
      .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
   );

   always #5 pclk = ~pclk;

   // Capture every report pulse (count of high cycles exposes multi-cycle pulses)
   always @(negedge pclk) begin
      if (mon_valid === 1'b1) begin
         valid_cnt++;
         cap_data = mon_data;
         cap_perr = mon_perr;
         cap_ferr = mon_ferr;
         cap_brk  = mon_break;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v);
      uart_line = v;
      repeat (DIV) @(negedge pclk);
   endtask

   task automatic idle(input int n);
      uart_line = 1'b1;
      repeat (n) @(negedge pclk);
   endtask

   task automatic set_cfg(input logic [1:0] wls, input logic pen, input logic eps, input logic stb);
      cfg_wls = wls;
      cfg_pen = pen;
      cfg_eps = eps;
      cfg_stb = stb;
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                             input logic pbit, input logic s1, input logic s2, input bit two);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i]);
      if (pen) drive_bit(pbit);
      drive_bit(s1);
      if (two) drive_bit(s2);
   endtask

   task automatic check_report(input string tag, input int dv, input logic [7:0] d,
                               input logic p, input logic f, input logic b);
      check({tag, "_nvalid"}, 32'(valid_cnt - v0), 32'(dv));
      check({tag, "_data"},   32'(cap_data), 32'(d));
      check({tag, "_perr"},   32'(cap_perr), 32'(p));
      check({tag, "_ferr"},   32'(cap_ferr), 32'(f));
      check({tag, "_break"},  32'(cap_brk),  32'(b));
      check({tag, "_frames"}, 32'(frame_cnt), 32'(ef));
      check({tag, "_errs"},   32'(err_cnt),   32'(ee));
   endtask

   initial begin
      // Reset state
      repeat (4) @(negedge pclk);
      check("rst_valid", 32'(mon_valid), 32'd0);
      check("rst_busy",  32'(mon_busy),  32'd0);
      check("rst_data",  32'(mon_data),  32'd0);
      check("rst_frames", 32'(frame_cnt), 32'd0);
      check("rst_errs",  32'(err_cnt),   32'd0);
      preset_n = 1'b1;
      idle(8);

      // 8N1 0xA5
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      v0 = valid_cnt;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      ef = 1; ee = 0;
      check_report("a5", 1, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("a5_busy", 32'(mon_busy), 32'd0);

      // 7E1 0x35 with wrong parity bit, then correct parity bit
      set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
      v0 = valid_cnt;
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(4);
      ef = 2; ee = 1;
      check_report("par_bad", 1, 8'h35, 1'b1, 1'b0, 1'b0);
      v0 = valid_cnt;
      send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      ef = 3;
      check_report("par_ok", 1, 8'h35, 1'b0, 1'b0, 1'b0);

      // 8N2 0x55 with second stop bit low
      set_cfg(2'b11, 1'b0, 1'b0, 1'b1);
      v0 = valid_cnt;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(4);
      ef = 4; ee = 2;
      check_report("ferr", 1, 8'h55, 1'b0, 1'b1, 1'b0);

      // Break: line low for 12 bit times
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      v0 = valid_cnt;
      repeat (12) drive_bit(1'b0);
      ef = 5; ee = 3;
      check_report("brk", 1, 8'h00, 1'b0, 1'b0, 1'b1);
      check("brk_busy_low", 32'(mon_busy), 32'd1);
      idle(6);
      check("brk_busy_high", 32'(mon_busy), 32'd0);
      check("brk_single", 32'(valid_cnt - v0), 32'd1);

      // 3-cycle glitch
      v0 = valid_cnt;
      uart_line = 1'b0;
      repeat (3) @(negedge pclk);
      idle(3 * DIV);
      check("glitch_nvalid", 32'(valid_cnt - v0), 32'd0);
      check("glitch_frames", 32'(frame_cnt), 32'(ef));
      check("glitch_busy", 32'(mon_busy), 32'd0);

      // Reset in the middle of the data bits of 0xC3
      v0 = valid_cnt;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      uart_line = 1'b0;
      repeat (8) @(negedge pclk);
      check("mid_busy", 32'(mon_busy), 32'd1);
      preset_n = 1'b0;
      uart_line = 1'b1;
      repeat (3) @(negedge pclk);
      preset_n = 1'b1;
      idle(3 * DIV);
      ef = 0; ee = 0;
      check("rst_mid_nvalid", 32'(valid_cnt - v0), 32'd0);
      check("rst_mid_frames", 32'(frame_cnt), 32'd0);
      check("rst_mid_errs", 32'(err_cnt), 32'd0);
      check("rst_mid_busy", 32'(mon_busy), 32'd0);
      check("rst_mid_data", 32'(mon_data), 32'd0);
      v0 = valid_cnt;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      ef = 1;
      check_report("post_rst", 1, 8'h3C, 1'b0, 1'b0, 1'b0);

      // Back-to-back frames, no idle gap
      v0 = valid_cnt;
      send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      ef = 3;
      check_report("b2b", 2, 8'hF0, 1'b0, 1'b0, 1'b0);

      // Error frames (8E1, 0x00 with parity 1) to wrap/saturate the 3-bit counters
      set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         send_frame(8'h00, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         idle(2);
      end
      ef = 10; ee = 7;
      check("sat_errs7", 32'(s_err_cnt), 32'd7);
      check("sat_frames_wrap", 32'(s_frame_cnt), 32'd2);
      check("big_errs7", 32'(err_cnt), 32'(ee));
      v0 = valid_cnt;
      send_frame(8'h00, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(4);
      ef = 11; ee = 8;
      check_report("sat_last", 1, 8'h00, 1'b1, 1'b0, 1'b0);
      check("sat_errs_hold", 32'(s_err_cnt), 32'd7);
      check("sat_frames", 32'(s_frame_cnt), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
